// File: rtl/pc_sequencer_if.sv
// Control/status bundle of the PC sequencer: next-PC select, jump operands, PC and return-stack status.
// Master drives the select/operand side and observes status; the sequencer is the slave.
interface pc_sequencer_if #(
    parameter int PC_W  = 12,
    parameter int OFF_W = 8,
    parameter int DEPTH = 8
);
    logic                     stall;
    logic [1:0]               pc_src;
    logic                     call;
    logic [PC_W-1:0]          target;
    logic [OFF_W-1:0]         offset;
    logic [PC_W-1:0]          pc;
    logic [PC_W-1:0]          ret_addr;
    logic [$clog2(DEPTH):0]   depth;
    logic                     stack_overflow;
    logic                     stack_underflow;

    modport master (
        output stall, pc_src, call, target, offset,
        input  pc, ret_addr, depth, stack_overflow, stack_underflow
    );

    modport slave (
        input  stall, pc_src, call, target, offset,
        output pc, ret_addr, depth, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with call/return stack: pc and depth update one edge after the select, ret_addr is combinational.
// stall=1 freezes every register; overflow/underflow flags are sticky until reset.
module pc_sequencer #(
    parameter int PC_W      = 12,
    parameter int OFF_W     = 8,
    parameter int DEPTH     = 8,
    parameter int WRAP_MODE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] depth_q, depth_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  stack_q [DEPTH];

    assign pc_inc  = pc_q + 1'b1;
    assign off_ext = PC_W'($signed(bus.offset));

    always_comb begin
        pc_d    = pc_inc;
        depth_d = depth_q;
        top_d   = top_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        case (bus.pc_src)
            2'b01: begin
                pc_d = bus.target;
                if (bus.call) begin
                    if (depth_q != FULL) begin
                        push    = 1'b1;
                        depth_d = depth_q + 1'b1;
                    end else begin
                        // Full stack: the slot after top holds the oldest entry.
                        ovf_d = 1'b1;
                        push  = (WRAP_MODE != 0);
                    end
                end
            end
            2'b10: begin
                if (depth_q != '0) begin
                    pc_d    = stack_q[top_q];
                    depth_d = depth_q - 1'b1;
                    top_d   = top_q - 1'b1;
                end else begin
                    unf_d = 1'b1;
                end
            end
            2'b11:   pc_d = pc_inc + off_ext;
            default: pc_d = pc_inc;
        endcase
        if (push) begin
            top_d = top_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            depth_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (!bus.stall) begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entries are left uncleared; depth_q gates their visibility.
    always_ff @(posedge clk) begin
        if (!bus.stall && push) begin
            stack_q[top_d] <= pc_inc;
        end
    end

    assign bus.pc              = pc_q;
    assign bus.depth           = depth_q;
    assign bus.ret_addr        = (depth_q == '0) ? '0 : stack_q[top_q];
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: drop-on-full and wrap-on-full instances share stimulus and are checked against a list-based model.
module tb_pc_sequencer;
    localparam int PC_W  = 12;
    localparam int OFF_W = 8;
    localparam int DEPTH = 8;
    localparam int PCMOD = 1 << PC_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(PC_W), .OFF_W(OFF_W), .DEPTH(DEPTH)) if0 ();
    pc_sequencer_if #(.PC_W(PC_W), .OFF_W(OFF_W), .DEPTH(DEPTH)) if1 ();

    pc_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .DEPTH(DEPTH), .WRAP_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    pc_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .DEPTH(DEPTH), .WRAP_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    // Model: ms[m][0] is the oldest entry, ms[m][mcnt[m]-1] the top.
    int mpc  [2];
    int mcnt [2];
    int ms   [2][DEPTH];
    bit mov  [2];
    bit mun  [2];
    string oname [5] = '{"pc", "depth", "ret_addr", "overflow", "underflow"};

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            mpc[m] = 0; mcnt[m] = 0; mov[m] = 1'b0; mun[m] = 1'b0;
        end
    endfunction

    function automatic void model_edge(input int src, input bit cl, input int tgt, input int off);
        for (int m = 0; m < 2; m++) begin
            int nxt;
            int soff;
            nxt = (mpc[m] + 1) % PCMOD;
            case (src)
                0: mpc[m] = nxt;
                1: begin
                    if (cl) begin
                        if (mcnt[m] < DEPTH) begin
                            ms[m][mcnt[m]] = nxt;
                            mcnt[m]++;
                        end else begin
                            mov[m] = 1'b1;
                            if (m == 1) begin
                                for (int i = 0; i < DEPTH - 1; i++) ms[m][i] = ms[m][i+1];
                                ms[m][DEPTH-1] = nxt;
                            end
                        end
                    end
                    mpc[m] = tgt;
                end
                2: begin
                    if (mcnt[m] > 0) begin
                        mcnt[m]--;
                        mpc[m] = ms[m][mcnt[m]];
                    end else begin
                        mun[m] = 1'b1;
                        mpc[m] = nxt;
                    end
                end
                default: begin
                    soff   = (off >= (1 << (OFF_W - 1))) ? off - (1 << OFF_W) : off;
                    mpc[m] = (((nxt + soff) % PCMOD) + PCMOD) % PCMOD;
                end
            endcase
        end
    endfunction

    function automatic logic [31:0] exp_v(input int m, input int k);
        case (k)
            0:       return 32'(mpc[m]);
            1:       return 32'(mcnt[m]);
            2:       return (mcnt[m] > 0) ? 32'(ms[m][mcnt[m]-1]) : 32'd0;
            3:       return {31'd0, mov[m]};
            default: return {31'd0, mun[m]};
        endcase
    endfunction

    function automatic logic [31:0] obs(input int m, input int k);
        case (k)
            0:       return (m == 0) ? 32'(if0.pc)             : 32'(if1.pc);
            1:       return (m == 0) ? 32'(if0.depth)          : 32'(if1.depth);
            2:       return (m == 0) ? 32'(if0.ret_addr)       : 32'(if1.ret_addr);
            3:       return (m == 0) ? 32'(if0.stack_overflow) : 32'(if1.stack_overflow);
            default: return (m == 0) ? 32'(if0.stack_underflow): 32'(if1.stack_underflow);
        endcase
    endfunction

    task automatic drive(input bit st, input int src, input bit cl, input int tgt, input int off);
        if0.stall = st; if0.pc_src = 2'(src); if0.call = cl; if0.target = PC_W'(tgt); if0.offset = OFF_W'(off);
        if1.stall = st; if1.pc_src = 2'(src); if1.call = cl; if1.target = PC_W'(tgt); if1.offset = OFF_W'(off);
    endtask

    task automatic step(input bit st, input int src, input bit cl, input int tgt, input int off);
        drive(st, src, cl, tgt, off);
        @(posedge clk);
        if (!st && rst_n) model_edge(src, cl, tgt, off);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (obs(m, k) !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_pulse dut%0d %s: got %0h expected 0", m, oname[k], obs(m, k));
                end
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, 0, 1'b0, 0, 0);
        rst_n = 1'b0;
        #12;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (obs(m, k) !== 32'd0) begin
                    errors++;
                    $display("FAIL reset dut%0d %s: got %0h expected 0", m, oname[k], obs(m, k));
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_increment();
        @(negedge clk);
        pulse_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (obs(m, k) !== ((k == 0) ? 32'd3 : 32'd0)) begin
                    errors++;
                    $display("FAIL increment dut%0d %s: got %0h expected %0h", m, oname[k], obs(m, k), (k == 0) ? 3 : 0);
                end
            end
        end
    endtask

    task automatic test_call_return();
        step(1'b0, 1, 1'b0, 'h010, 0);
        step(1'b0, 1, 1'b1, 'h200, 0);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m, 0) !== 32'h200 || obs(m, 1) !== 32'd1 || obs(m, 2) !== 32'h011) begin
                errors++;
                $display("FAIL call dut%0d: got pc=%0h depth=%0d ret=%0h expected pc=200 depth=1 ret=11",
                         m, obs(m, 0), obs(m, 1), obs(m, 2));
            end
        end
        step(1'b0, 2, 1'b0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m, 0) !== 32'h011 || obs(m, 1) !== 32'd0 || obs(m, 2) !== 32'd0) begin
                errors++;
                $display("FAIL return dut%0d: got pc=%0h depth=%0d ret=%0h expected pc=11 depth=0 ret=0",
                         m, obs(m, 0), obs(m, 1), obs(m, 2));
            end
        end
    endtask

    task automatic test_branch_wrap();
        step(1'b0, 1, 1'b0, 'h005, 0);
        step(1'b0, 3, 1'b0, 0, 'hFA);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m, 0) !== 32'h000) begin
                errors++;
                $display("FAIL branch_neg dut%0d: got pc=%0h expected 0", m, obs(m, 0));
            end
        end
        step(1'b0, 1, 1'b0, 'hFFF, 0);
        step(1'b0, 0, 1'b0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m, 0) !== 32'h000) begin
                errors++;
                $display("FAIL pc_wrap dut%0d: got pc=%0h expected 0", m, obs(m, 0));
            end
        end
        step(1'b0, 1, 1'b0, 'hFF0, 0);
        step(1'b0, 3, 1'b0, 0, 'h7F);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m, 0) !== 32'h070) begin
                errors++;
                $display("FAIL branch_pos_wrap dut%0d: got pc=%0h expected 70", m, obs(m, 0));
            end
        end
    endtask

    task automatic test_overflow_underflow();
        pulse_reset();
        for (int i = 0; i < 9; i++) step(1'b0, 1, 1'b1, i + 1, 0);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m, 1) !== 32'd8 || obs(m, 3) !== 32'd1 || obs(m, 4) !== 32'd0) begin
                errors++;
                $display("FAIL overflow dut%0d: got depth=%0d ovf=%0d unf=%0d expected 8 1 0",
                         m, obs(m, 1), obs(m, 3), obs(m, 4));
            end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2, 1'b0, 0, 0);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m, 0) !== 32'(8 - i + m) || obs(m, 1) !== 32'(7 - i)) begin
                    errors++;
                    $display("FAIL pop%0d dut%0d: got pc=%0d depth=%0d expected pc=%0d depth=%0d",
                             i, m, obs(m, 0), obs(m, 1), 8 - i + m, 7 - i);
                end
            end
        end
        step(1'b0, 2, 1'b0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m, 0) !== 32'(2 + m) || obs(m, 1) !== 32'd0 || obs(m, 4) !== 32'd1 || obs(m, 3) !== 32'd1) begin
                errors++;
                $display("FAIL underflow dut%0d: got pc=%0d depth=%0d unf=%0d ovf=%0d expected pc=%0d 0 1 1",
                         m, obs(m, 0), obs(m, 1), obs(m, 4), obs(m, 3), 2 + m);
            end
        end
    endtask

    task automatic test_stall();
        pulse_reset();
        step(1'b0, 1, 1'b1, 'h100, 0);
        step(1'b0, 1, 1'b1, 'h200, 0);
        for (int e = 0; e < 4; e++) begin
            step(1'b1, 2, 1'b0, 0, 0);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs(m, 0) !== 32'h200 || obs(m, 1) !== 32'd2 || obs(m, 2) !== 32'h101) begin
                    errors++;
                    $display("FAIL stall%0d dut%0d: got pc=%0h depth=%0d ret=%0h expected 200 2 101",
                             e, m, obs(m, 0), obs(m, 1), obs(m, 2));
                end
            end
        end
        pulse_reset();
        step(1'b0, 0, 1'b0, 0, 0);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs(m, 0) !== 32'd1 || obs(m, 1) !== 32'd0 || obs(m, 2) !== 32'd0) begin
                errors++;
                $display("FAIL post_reset dut%0d: got pc=%0h depth=%0d ret=%0h expected 1 0 0",
                         m, obs(m, 0), obs(m, 1), obs(m, 2));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bit st;
            int src;
            if ($urandom_range(0, 99) == 0) pulse_reset();
            st  = ($urandom_range(0, 7) == 0);
            src = $urandom_range(0, 3);
            step(st, src, 1'($urandom_range(0, 1)), $urandom_range(0, PCMOD - 1), $urandom_range(0, 255));
            for (int m = 0; m < 2; m++) begin
                for (int k = 0; k < 5; k++) begin
                    checks++;
                    if (obs(m, k) !== exp_v(m, k)) begin
                        errors++;
                        $display("FAIL random%0d dut%0d %s: got %0h expected %0h", n, m, oname[k], obs(m, k), exp_v(m, k));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_call_return();
        test_branch_wrap();
        test_overflow_underflow();
        test_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
